// File: rtl/tt09_aes_sequencer.sv
// tt09_aes_sequencer
//   Host-side sequencer for an external AES core. The host streams key and
//   plaintext bytes in (MSB byte first), requests an encryption, and reads the
//   ciphertext back one byte at a time with a valid/ack handshake. A watchdog
//   aborts a run if the core never reports completion.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   ena                design selected; low freezes every register
//   in_data/strobe/sel host load byte, load pulse, target (0 key, 1 text)
//   start, clr         encrypt request; clear of byte counts and err (IDLE only)
//   out_ack            host consumed out_data
//   core_done/result   completion pulse and ciphertext from the AES core
//   core_key/text      key and plaintext registers to the core
//   core_start         one-cycle core launch pulse
//   out_data/valid     result byte stream (out_data is 0 when not valid)
//   busy, err          FSM not idle; sticky error flag
module tt09_aes_sequencer #(
  parameter int unsigned NBYTES = 16,
  parameter int unsigned WDOG   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [7:0]            in_data,
  input  logic                  in_strobe,
  input  logic                  in_sel,
  input  logic                  start,
  input  logic                  clr,
  input  logic                  out_ack,
  input  logic                  core_done,
  input  logic [8*NBYTES-1:0]   core_result,
  output logic [8*NBYTES-1:0]   core_key,
  output logic [8*NBYTES-1:0]   core_text,
  output logic                  core_start,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned CntW = $clog2(NBYTES + 1);
  localparam int unsigned WdW  = $clog2(WDOG + 1);

  localparam logic [CntW-1:0] CntFull = CntW'(NBYTES);
  localparam logic [CntW-1:0] LastIdx = CntW'(NBYTES - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(WDOG - 1);

  typedef enum logic [1:0] {StIdle, StRun, StUnload} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    key_q, key_d;
  logic [W-1:0]    text_q, text_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CntW-1:0] key_cnt_q, key_cnt_d;
  logic [CntW-1:0] txt_cnt_q, txt_cnt_d;
  logic [CntW-1:0] idx_q, idx_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic            core_start_q, core_start_d;
  logic            out_valid_q, out_valid_d;
  logic            err_q, err_d;

  // Byte number idx lands in the idx-th byte counted from the MSB end.
  function automatic logic [W-1:0] put_byte(input logic [W-1:0]    r,
                                            input logic [CntW-1:0] idx,
                                            input logic [7:0]      b);
    logic [W-1:0] v;
    v = r;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx == CntW'(i)) v[W-8-8*i +: 8] = b;
    end
    return v;
  endfunction

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    text_d       = text_q;
    shift_d      = shift_q;
    key_cnt_d    = key_cnt_q;
    txt_cnt_d    = txt_cnt_q;
    idx_d        = idx_q;
    wdog_d       = wdog_q;
    out_valid_d  = out_valid_q;
    err_d        = err_q;
    // The launch pulse only lasts one enabled cycle; a frozen design holds it.
    core_start_d = ena ? 1'b0 : core_start_q;

    if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (clr) begin
            key_cnt_d = '0;
            txt_cnt_d = '0;
            err_d     = 1'b0;
          end else if (start) begin
            if (key_cnt_q == CntFull && txt_cnt_q == CntFull) begin
              state_d      = StRun;
              core_start_d = 1'b1;
              wdog_d       = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (in_strobe) begin
            if (in_sel) begin
              if (txt_cnt_q == CntFull) begin
                err_d = 1'b1;
              end else begin
                text_d    = put_byte(text_q, txt_cnt_q, in_data);
                txt_cnt_d = txt_cnt_q + 1'b1;
              end
            end else begin
              if (key_cnt_q == CntFull) begin
                err_d = 1'b1;
              end else begin
                key_d     = put_byte(key_q, key_cnt_q, in_data);
                key_cnt_d = key_cnt_q + 1'b1;
              end
            end
          end
        end

        StRun: begin
          // core_done is tested first so it wins over a simultaneous timeout.
          if (core_done) begin
            shift_d     = core_result;
            idx_d       = '0;
            out_valid_d = 1'b1;
            state_d     = StUnload;
          end else if (wdog_q == WdLast) begin
            err_d     = 1'b1;
            txt_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end

        StUnload: begin
          if (out_valid_q && out_ack) begin
            if (idx_q == LastIdx) begin
              out_valid_d = 1'b0;
              shift_d     = '0;
              txt_cnt_d   = '0;
              state_d     = StIdle;
            end else begin
              shift_d = shift_q << 8;
              idx_d   = idx_q + 1'b1;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      key_q        <= '0;
      text_q       <= '0;
      shift_q      <= '0;
      key_cnt_q    <= '0;
      txt_cnt_q    <= '0;
      idx_q        <= '0;
      wdog_q       <= '0;
      core_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      text_q       <= text_d;
      shift_q      <= shift_d;
      key_cnt_q    <= key_cnt_d;
      txt_cnt_q    <= txt_cnt_d;
      idx_q        <= idx_d;
      wdog_q       <= wdog_d;
      core_start_q <= core_start_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
    end
  end

  assign core_key   = key_q;
  assign core_text  = text_q;
  assign core_start = core_start_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_valid_q ? shift_q[W-1 -: 8] : 8'h00;
  assign busy       = (state_q != StIdle);
  assign err        = err_q;

endmodule

// File: tb/tb_tt09_aes_sequencer.sv
// Bench for tt09_aes_sequencer: directed scenarios plus randomized blocks,
// every cycle compared against a byte-array/queue model of the sequencer.
module tb_tt09_aes_sequencer;

  localparam int NB = 16;
  localparam int WD = 255;

  typedef logic [7:0] blk_t [NB];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_strobe = 1'b0;
  logic         in_sel = 1'b0;
  logic         start = 1'b0;
  logic         clr = 1'b0;
  logic         out_ack = 1'b0;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;
  logic [127:0] core_key;
  logic [127:0] core_text;
  logic         core_start;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         busy;
  logic         err;

  tt09_aes_sequencer #(.NBYTES(NB), .WDOG(WD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_data    (in_data),
    .in_strobe  (in_strobe),
    .in_sel     (in_sel),
    .start      (start),
    .clr        (clr),
    .out_ack    (out_ack),
    .core_done  (core_done),
    .core_result(core_result),
    .core_key   (core_key),
    .core_text  (core_text),
    .core_start (core_start),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;
  bit stall_en = 1'b0;

  // Model: 0 idle, 1 waiting for the core, 2 handing out result bytes.
  blk_t       m_key;
  blk_t       m_text;
  int         m_kc, m_tc, m_mode, m_runc;
  bit         m_err, m_cs;
  logic [7:0] m_q[$];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] pack(input blk_t b);
    logic [127:0] v;
    for (int i = 0; i < NB; i++) v[127-8*i -: 8] = b[i];
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_key[i]  = 8'h00;
      m_text[i] = 8'h00;
    end
    m_kc = 0; m_tc = 0; m_mode = 0; m_runc = 0;
    m_err = 1'b0; m_cs = 1'b0;
    m_q.delete();
  endtask

  // One enabled clock as seen by the spec rules, using the inputs being driven.
  task automatic model_step();
    if (!ena) return;
    m_cs = 1'b0;
    case (m_mode)
      0: begin
        if (clr) begin
          m_kc = 0; m_tc = 0; m_err = 1'b0;
        end else if (start) begin
          if (m_kc == NB && m_tc == NB) begin
            m_mode = 1; m_cs = 1'b1; m_runc = 0;
          end else m_err = 1'b1;
        end else if (in_strobe) begin
          if (in_sel) begin
            if (m_tc == NB) m_err = 1'b1;
            else begin m_text[m_tc] = in_data; m_tc++; end
          end else begin
            if (m_kc == NB) m_err = 1'b1;
            else begin m_key[m_kc] = in_data; m_kc++; end
          end
        end
      end
      1: begin
        if (core_done) begin
          m_q.delete();
          for (int i = 0; i < NB; i++) m_q.push_back(core_result[127-8*i -: 8]);
          m_mode = 2;
        end else begin
          m_runc++;
          if (m_runc == WD) begin
            m_err = 1'b1; m_tc = 0; m_mode = 0;
          end
        end
      end
      default: begin
        if (out_ack) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_mode = 0; m_tc = 0;
          end
        end
      end
    endcase
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", 128'(out_valid), 128'(m_mode == 2));
      chk("out_data", 128'(out_data),
          128'((m_mode == 2 && m_q.size() > 0) ? m_q[0] : 8'h00));
      chk("busy", 128'(busy), 128'(m_mode != 0));
      chk("err", 128'(err), 128'(m_err));
      chk("core_start", 128'(core_start), 128'(m_cs));
      chk("core_key", core_key, pack(m_key));
      chk("core_text", core_text, pack(m_text));
    end
  end

  // Optionally inserts a frozen (ena=0) cycle with the same inputs first.
  task automatic cyc();
    if (stall_en && $urandom_range(0, 5) == 0) begin
      ena = 1'b0;
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      ena = 1'b1;
    end
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic load_byte(input logic sel, input logic [7:0] d);
    in_sel = sel; in_data = d; in_strobe = 1'b1;
    cyc();
    in_strobe = 1'b0;
  endtask

  task automatic load_blk(input logic sel, input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) load_byte(sel, v[127-8*i -: 8]);
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  // Stub core: core_done after dly further cycles; counts observed launch pulses.
  task automatic core_run(input int dly, input logic [127:0] res, output int pulses);
    pulses = int'(core_start);
    for (int i = 0; i < dly; i++) begin
      core_result = rand128();
      cyc();
      pulses += int'(core_start);
    end
    core_done = 1'b1; core_result = res;
    cyc();
    pulses += int'(core_start);
    core_done = 1'b0; core_result = rand128();
  endtask

  // Acks up to nlim bytes; gaps of 0..gapmax idle cycles unless ack is held.
  task automatic unload(input int gapmax, input bit hold, input int nlim,
                        output logic [127:0] got, output int vcyc);
    int n = 0;
    int budget = 200;
    int gap;
    got = '0; vcyc = 0;
    gap = hold ? 0 : $urandom_range(0, gapmax);
    while (n < nlim && budget > 0) begin
      budget--;
      if (out_valid) vcyc++;
      if (gap > 0) begin out_ack = 1'b0; gap--; end
      else out_ack = 1'b1;
      if (!hold) begin
        // Loads, starts and clears must be ignored here.
        in_strobe = ($urandom_range(0, 3) == 0);
        in_sel = 1'($urandom);
        in_data = 8'($urandom);
        start = ($urandom_range(0, 5) == 0);
        clr = ($urandom_range(0, 5) == 0);
      end
      if (out_valid && out_ack) begin
        got[127-8*n -: 8] = out_data;
        n++;
        gap = hold ? 0 : $urandom_range(0, gapmax);
      end
      cyc();
    end
    out_ack = 1'b0; in_strobe = 1'b0; start = 1'b0; clr = 1'b0;
    if (budget == 0) chk("unload_budget", 128'(n), 128'(nlim));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [127:0] got, k, t;
    int p, vc, n;
    logic [127:0] fips_key, fips_txt, fips_res;
    fips_key = 128'h000102030405060708090a0b0c0d0e0f;
    fips_txt = 128'h00112233445566778899aabbccddeeff;
    fips_res = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    model_reset();
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_key", core_key, 128'd0);
    chk("rst_valid", 128'(out_valid), 128'd0);
    rst_n = 1'b1;
    cyc();

    // FIPS-197 C.1, ack held high even while the core runs.
    load_blk(1'b0, fips_key, NB);
    load_blk(1'b1, fips_txt, NB);
    out_ack = 1'b1;
    do_start();
    core_run(10, fips_res, p);
    chk("fips_cs_pulses", 128'(p), 128'd1);
    unload(0, 1'b1, NB, got, vc);
    chk("fips_bytes", got, fips_res);
    chk("fips_consecutive", 128'(vc), 128'd16);
    chk("fips_idle", 128'(busy), 128'd0);
    chk("fips_err", 128'(err), 128'd0);

    // Start with 15 text bytes.
    do_clr();
    load_blk(1'b0, rand128(), NB);
    load_blk(1'b1, rand128(), NB - 1);
    do_start();
    chk("short_err", 128'(err), 128'd1);
    chk("short_cs", 128'(core_start), 128'd0);
    chk("short_busy", 128'(busy), 128'd0);
    clr = 1'b1; in_strobe = 1'b1; in_sel = 1'b1; in_data = 8'h5a;
    cyc();
    clr = 1'b0; in_strobe = 1'b0;
    chk("clr_err", 128'(err), 128'd0);
    do_start();
    chk("clr_counts_zero", 128'(err), 128'd1);
    do_clr();

    // Watchdog: core never answers.
    k = rand128();
    load_blk(1'b0, k, NB);
    load_blk(1'b1, rand128(), NB);
    do_start();
    n = 0;
    while (busy && n < 400) begin
      n++;
      cyc();
    end
    chk("wdog_cycles", 128'(n), 128'(WD));
    chk("wdog_err", 128'(err), 128'd1);
    chk("wdog_key_kept", core_key, k);
    // Text reload only; core_done lands on the final watchdog cycle and wins.
    load_blk(1'b1, rand128(), NB);
    do_start();
    chk("restart_cs", 128'(core_start), 128'd1);
    t = rand128();
    core_run(WD - 1, t, p);
    chk("done_wins", 128'(out_valid), 128'd1);
    unload(3, 1'b0, NB, got, vc);
    chk("done_wins_bytes", got, t);

    // 17th key strobe.
    do_clr();
    k = rand128();
    load_blk(1'b0, k, NB);
    load_byte(1'b0, 8'ha5);
    chk("key17_err", 128'(err), 128'd1);
    chk("key17_key", core_key, k);

    // Reset in the middle of unloading, after five bytes.
    do_clr();
    stall_en = 1'b1;
    load_blk(1'b1, rand128(), NB);
    load_blk(1'b0, rand128(), NB);
    do_start();
    core_run(5, rand128(), p);
    unload(2, 1'b0, 5, got, vc);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'd0);
    chk("arst_data", 128'(out_data), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_key", core_key, 128'd0);
    chk("arst_text", core_text, 128'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    chk("post_rst_reload", 128'(err), 128'd1);
    chk("post_rst_busy", 128'(busy), 128'd0);

    // Randomized blocks with frozen cycles sprinkled in.
    for (int it = 0; it < 25; it++) begin
      do_clr();
      load_blk(1'b0, rand128(), NB);
      if ($urandom_range(0, 3) == 0) load_byte(1'b0, 8'($urandom));
      load_blk(1'b1, rand128(), NB);
      do_start();
      core_run($urandom_range(0, 40), rand128(), p);
      unload(3, 1'b0, NB, got, vc);
    end

    stall_en = 1'b0;
    cyc();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt09_aes_sequencer.md
TT09_AES_SEQUENCER -- requirements
Module: tt09_aes_sequencer

Interface
REQ-001 SHALL have parameter NBYTES, default 16: bytes per key and per data block.
REQ-002 SHALL have parameter WDOG, default 255: maximum RUN cycles before timeout.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port ena, input, 1: design selected; low freezes all state.
REQ-006 SHALL have port in_data, input, 8: host load byte.
REQ-007 SHALL have port in_strobe, input, 1: one-cycle load pulse.
REQ-008 SHALL have port in_sel, input, 1: load target, 0=key, 1=text.
REQ-009 SHALL have port start, input, 1: one-cycle encrypt request.
REQ-010 SHALL have port clr, input, 1: synchronous clear of byte counts and err.
REQ-011 SHALL have port out_ack, input, 1: host consumed out_data.
REQ-012 SHALL have port core_done, input, 1: AES core finished, one-cycle pulse.
REQ-013 SHALL have port core_result, input, 8*NBYTES: AES core ciphertext.
REQ-014 SHALL have port core_key, output, 8*NBYTES: key register to core.
REQ-015 SHALL have port core_text, output, 8*NBYTES: plaintext register to core.
REQ-016 SHALL have port core_start, output, 1: one-cycle core launch pulse.
REQ-017 SHALL have port out_data, output, 8: result byte.
REQ-018 SHALL have port out_valid, output, 1: out_data holds a valid byte.
REQ-019 SHALL have port busy, output, 1: FSM not in IDLE.
REQ-020 SHALL have port err, output, 1: sticky error flag.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, UNLOAD; busy=1 in RUN and UNLOAD.
REQ-022 SHALL, when ena=0, hold every register and ignore every input except rst_n.
REQ-023 SHALL accept in_strobe only in IDLE; each accepted byte is written to the selected register MSB-first (first byte -> bits [8*NBYTES-1 : 8*NBYTES-8]), and that register's count increments.
REQ-024 SHALL keep separate key and text counts (0..NBYTES); a strobe at count NBYTES is dropped and sets err.
REQ-025 SHALL, on start in IDLE with both counts == NBYTES, pulse core_start for exactly one cycle on the following cycle and enter RUN.
REQ-026 SHALL, on start in IDLE with either count < NBYTES, set err and stay in IDLE.
REQ-027 SHALL ignore start and in_strobe while in RUN or UNLOAD, without setting err.
REQ-028 SHALL, in RUN, capture core_result into the output shift register on the core_done cycle and enter UNLOAD on the next cycle with out_valid=1 and out_data = MSB byte.
REQ-029 SHALL, in RUN, count cycles; if WDOG cycles elapse with no core_done, set err, clear the text count, and return to IDLE; a core_done arriving on the same cycle as timeout wins.
REQ-030 SHALL, in UNLOAD, hold out_data/out_valid stable until out_ack; on out_valid&out_ack advance to the next byte on the next cycle (back-to-back acks give one byte per cycle).
REQ-031 SHALL, on ack of byte NBYTES-1, drop out_valid next cycle, clear the text count, retain the key and key count, and return to IDLE.
REQ-032 SHALL ignore out_ack when out_valid=0.
REQ-033 SHALL, on clr, zero both counts and err in IDLE only; clr outside IDLE is ignored; clr overrides a simultaneous in_strobe.
REQ-034 SHALL drive out_data=0 whenever out_valid=0.

Reset
REQ-035 SHALL, on rst_n low, immediately set state IDLE, both counts 0, core_key=0, core_text=0, core_start=0, out_data=0, out_valid=0, busy=0, err=0, and the watchdog counter 0, regardless of state.
REQ-036 SHALL resume only on the first rising clk edge after rst_n deasserts; reset mid-RUN or mid-UNLOAD discards the block.

Verification
REQ-037 SHALL cover FIPS-197 C.1 vector: load key 000102..0f and text 00112233..ff, start, stub core_done after 11 cycles with result 69c4e0d8..c55a -> core_start single pulse, out bytes 69,c4,...,5a in order, then IDLE, err=0.
REQ-038 SHALL cover a start issued with 15 text bytes loaded -> err=1, no core_start, busy=0; a subsequent clr -> err=0 and counts=0.
REQ-039 SHALL cover a stub core that never asserts done -> err=1 and IDLE after exactly WDOG RUN cycles; the key is retained, and reloading 16 text bytes plus start succeeds.
REQ-040 SHALL cover out_ack held high continuously -> 16 bytes in 16 consecutive cycles; with ack gaps of 0-3 random cycles, data is stable while unacked.
REQ-041 SHALL cover a 17th key strobe -> err=1 and the key unchanged; ena=0 pulses during load and UNLOAD -> no state or output change.
REQ-042 SHALL cover rst_n asserted mid-UNLOAD after byte 5 -> all outputs 0 asynchronously, and the next block requires a full reload.
